// File: rtl/axis_eth_rx_arbiter_pkg.sv
// rtl/axis_eth_rx_arbiter_pkg.sv - shared types for the Ethernet RX frame arbiter
package EthernetBus;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        FLUSH   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axis_eth_rx_arbiter_if.sv
// rtl/axis_eth_rx_arbiter_if.sv - per-port RX streams, merged TX stream and statistics bundle
interface axis_eth_rx_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CTR_WIDTH  = 32
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int DEST_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]            link_up;
    logic [NUM_PORTS-1:0]            rx_tvalid;
    logic [NUM_PORTS-1:0]            rx_tready;
    logic [NUM_PORTS-1:0]            rx_tlast;
    logic [NUM_PORTS-1:0]            rx_tuser;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rx_tdata;
    logic [NUM_PORTS*KEEP_W-1:0]     rx_tkeep;

    logic                            tx_tvalid;
    logic                            tx_tready;
    logic [DATA_WIDTH-1:0]           tx_tdata;
    logic [KEEP_W-1:0]               tx_tkeep;
    logic                            tx_tlast;
    logic                            tx_tuser;
    logic [DEST_W-1:0]               tx_tdest;

    logic [NUM_PORTS*CTR_WIDTH-1:0]  frame_count;
    logic [NUM_PORTS*CTR_WIDTH-1:0]  drop_count;

    modport master (
        output link_up, rx_tvalid, rx_tlast, rx_tuser, rx_tdata, rx_tkeep, tx_tready,
        input  rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser, tx_tdest,
        input  frame_count, drop_count
    );

    modport slave (
        input  link_up, rx_tvalid, rx_tlast, rx_tuser, rx_tdata, rx_tkeep, tx_tready,
        output rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser, tx_tdest,
        output frame_count, drop_count
    );

endinterface

// File: rtl/axis_eth_rx_arbiter_rr_grant.sv
// rtl/axis_eth_rx_arbiter_rr_grant.sv - combinational round-robin search starting after last_grant
module axis_rr_grant #(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [$clog2(NUM_PORTS)-1:0] last_grant_i,
    output logic [NUM_PORTS-1:0]         grant_o,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx_o
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    logic found;
    int   cand;

    // last_grant < NUM_PORTS and i < NUM_PORTS, so one subtraction gives the modulo
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(last_grant_i) + 1 + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found                       = 1'b1;
                grant_o[cand[IDX_W-1:0]]    = 1'b1;
                grant_idx_o                 = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_eth_rx_arbiter.sv
// rtl/axis_eth_rx_arbiter.sv - frame-granular round-robin merge of Ethernet RX streams
// Statistics counters exist only when AXIS_ETH_RX_ARBITER_STATS_EN is defined.
module axis_eth_rx_arbiter
    import EthernetBus::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CTR_WIDTH  = 32
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    axis_eth_rx_arbiter_if.slave bus
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_PORTS);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;

    logic                  tx_tvalid_q, tx_tvalid_d;
    logic [DATA_WIDTH-1:0] tx_tdata_q, tx_tdata_d;
    logic [KEEP_W-1:0]     tx_tkeep_q, tx_tkeep_d;
    logic                  tx_tlast_q, tx_tlast_d;
    logic                  tx_tuser_q, tx_tuser_d;
    logic [IDX_W-1:0]      tx_tdest_q, tx_tdest_d;

    logic [NUM_PORTS-1:0]  rr_req, rr_oh;
    logic [IDX_W-1:0]      rr_idx;
    logic                  rr_valid;

    logic                  g_tvalid, g_tlast, g_tuser, g_link;
    logic [DATA_WIDTH-1:0] g_tdata;
    logic [KEEP_W-1:0]     g_tkeep;
    logic                  can_load, g_ready, fwd_done;
    logic [NUM_PORTS-1:0]  rdy, disc_last;

    assign rr_req = bus.rx_tvalid & bus.link_up;

    axis_rr_grant #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_grant (
        .req_i        (rr_req),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_oh),
        .grant_idx_o  (rr_idx)
    );

    assign rr_valid = |rr_oh;

    assign g_tvalid = bus.rx_tvalid[grant_q];
    assign g_tlast  = bus.rx_tlast[grant_q];
    assign g_tuser  = bus.rx_tuser[grant_q];
    assign g_link   = bus.link_up[grant_q];
    assign g_tdata  = bus.rx_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign g_tkeep  = bus.rx_tkeep[grant_q*KEEP_W +: KEEP_W];

    assign can_load = !tx_tvalid_q || bus.tx_tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tx_tvalid_d  = tx_tvalid_q;
        tx_tdata_d   = tx_tdata_q;
        tx_tkeep_d   = tx_tkeep_q;
        tx_tlast_d   = tx_tlast_q;
        tx_tuser_d   = tx_tuser_q;
        tx_tdest_d   = tx_tdest_q;
        g_ready      = 1'b0;
        fwd_done     = 1'b0;

        if (tx_tvalid_q && bus.tx_tready) begin
            tx_tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    grant_d = rr_idx;
                    state_d = FORWARD;
                end
            end
            FORWARD: begin
                g_ready = can_load;
                if (can_load) begin
                    // a tlast beat arriving with the link drop still completes the frame
                    if (g_tvalid && (g_link || g_tlast)) begin
                        tx_tvalid_d = 1'b1;
                        tx_tdata_d  = g_tdata;
                        tx_tkeep_d  = g_tkeep;
                        tx_tlast_d  = g_tlast;
                        tx_tuser_d  = g_tuser;
                        tx_tdest_d  = grant_q;
                        if (g_tlast) begin
                            fwd_done     = 1'b1;
                            last_grant_d = grant_q;
                            state_d      = IDLE;
                        end
                    end else if (!g_link) begin
                        // synthetic terminator; any non-last beat taken this cycle is dropped
                        tx_tvalid_d = 1'b1;
                        tx_tdata_d  = '0;
                        tx_tkeep_d  = '0;
                        tx_tlast_d  = 1'b1;
                        tx_tuser_d  = 1'b1;
                        tx_tdest_d  = grant_q;
                        state_d     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                g_ready = 1'b1;
                if (g_tvalid && g_tlast) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // link-down ports are drained so a dead PHY never backs up its MAC
    always_comb begin
        rdy       = ~bus.link_up;
        disc_last = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (state_q != IDLE && grant_q == IDX_W'(p)) begin
                rdy[p] = g_ready;
            end
            disc_last[p] = bus.rx_tvalid[p] && bus.rx_tlast[p] && rdy[p]
                           && !(state_q == FORWARD && grant_q == IDX_W'(p));
        end
    end

    assign bus.rx_tready = areset_n ? rdy : '0;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            tx_tvalid_q  <= 1'b0;
            tx_tdata_q   <= '0;
            tx_tkeep_q   <= '0;
            tx_tlast_q   <= 1'b0;
            tx_tuser_q   <= 1'b0;
            tx_tdest_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tx_tvalid_q  <= tx_tvalid_d;
            tx_tdata_q   <= tx_tdata_d;
            tx_tkeep_q   <= tx_tkeep_d;
            tx_tlast_q   <= tx_tlast_d;
            tx_tuser_q   <= tx_tuser_d;
            tx_tdest_q   <= tx_tdest_d;
        end
    end

    assign bus.tx_tvalid = tx_tvalid_q;
    assign bus.tx_tdata  = tx_tdata_q;
    assign bus.tx_tkeep  = tx_tkeep_q;
    assign bus.tx_tlast  = tx_tlast_q;
    assign bus.tx_tuser  = tx_tuser_q;
    assign bus.tx_tdest  = tx_tdest_q;

`ifdef AXIS_ETH_RX_ARBITER_STATS_EN
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
        logic [CTR_WIDTH-1:0] frame_cnt_q;
        logic [CTR_WIDTH-1:0] drop_cnt_q;

        always_ff @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
                frame_cnt_q <= '0;
                drop_cnt_q  <= '0;
            end else begin
                if (fwd_done && grant_q == IDX_W'(p)) begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
                if (disc_last[p]) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
        end

        assign bus.frame_count[p*CTR_WIDTH +: CTR_WIDTH] = frame_cnt_q;
        assign bus.drop_count[p*CTR_WIDTH +: CTR_WIDTH]  = drop_cnt_q;
    end
`else
    logic unused_stats;
    assign unused_stats    = ^{fwd_done, disc_last};
    assign bus.frame_count = {NUM_PORTS*CTR_WIDTH{1'b0}};
    assign bus.drop_count  = {NUM_PORTS*CTR_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_axis_eth_rx_arbiter.sv
// tb/tb_axis_eth_rx_arbiter.sv - directed self-checking bench for axis_eth_rx_arbiter
module tb_axis_eth_rx_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic        dest;
    } obeat_t;

`ifdef AXIS_ETH_RX_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic aclk;
    logic areset_n;

    axis_eth_rx_arbiter_if #(.NUM_PORTS(2), .DATA_WIDTH(32), .CTR_WIDTH(32)) bus ();

    axis_eth_rx_arbiter #(
        .NUM_PORTS  (2),
        .DATA_WIDTH (32),
        .CTR_WIDTH  (32)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int     errors = 0;
    int     checks = 0;
    beat_t  src0[$];
    beat_t  src1[$];
    obeat_t out_q[$];
    obeat_t exp_q[$];
    int     consumed[2];
    bit     fire0, fire1;
    beat_t  b0, b1;

    always @(negedge aclk) begin
        fire0 = bus.rx_tvalid[0] && bus.rx_tready[0];
        fire1 = bus.rx_tvalid[1] && bus.rx_tready[1];
        if (bus.tx_tvalid && bus.tx_tready) begin
            out_q.push_back({bus.tx_tdata, bus.tx_tkeep, bus.tx_tlast, bus.tx_tuser, bus.tx_tdest});
        end
    end

    always @(posedge aclk) begin
        #1;
        if (fire0 && src0.size() > 0) begin
            void'(src0.pop_front());
            consumed[0]++;
        end
        if (fire1 && src1.size() > 0) begin
            void'(src1.pop_front());
            consumed[1]++;
        end
        b0 = (src0.size() > 0) ? src0[0] : '0;
        b1 = (src1.size() > 0) ? src1[0] : '0;
        bus.rx_tvalid      = {src1.size() > 0, src0.size() > 0};
        bus.rx_tdata       = {b1.data, b0.data};
        bus.rx_tkeep       = {b1.keep, b0.keep};
        bus.rx_tlast       = {b1.last, b0.last};
        bus.rx_tuser       = {b1.user, b0.user};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cnt(input logic [63:0] v);
        return STATS ? v : 64'd0;
    endfunction

    function automatic obeat_t ob(input logic [31:0] d, input logic [3:0] k,
                                  input logic l, input logic u, input logic dst);
        return {d, k, l, u, dst};
    endfunction

    task automatic push_frame(input int port, input logic [31:0] base, input int n, input logic user_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = {base + 32'(i), 4'hF, (i == n - 1), user_last && (i == n - 1)};
            if (port == 0) src0.push_back(b);
            else           src1.push_back(b);
        end
    endtask

    task automatic exp_frame(input logic [31:0] base, input int n, input logic user_last, input logic dst);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ob(base + 32'(i), 4'hF, (i == n - 1), user_last && (i == n - 1), dst));
        end
    endtask

    task automatic wait_consumed(input int p, input int n);
        int k = 0;
        while (consumed[p] < n && k < 200) begin
            @(posedge aclk);
            #2;
            k++;
        end
        check($sformatf("consumed%0d", p), 64'(consumed[p]), 64'(n));
    endtask

    task automatic run_check(input string tag);
        int k = 0;
        while (out_q.size() < exp_q.size() && k < 300) begin
            @(posedge aclk);
            k++;
        end
        repeat (8) @(posedge aclk);
        #2;
        check({tag, " beats"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < out_q.size()) begin
                check($sformatf("%s beat%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
            end
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        areset_n      = 1'b0;
        bus.link_up   = 2'b11;
        bus.tx_tready = 1'b1;
        consumed[0]   = 0;
        consumed[1]   = 0;

        repeat (3) @(posedge aclk);
        #2;
        check("rst tx_tvalid", 64'(bus.tx_tvalid), 64'd0);
        check("rst tx_tdata", 64'(bus.tx_tdata), 64'd0);
        check("rst tx_tkeep", 64'(bus.tx_tkeep), 64'd0);
        check("rst tx_tlast", 64'(bus.tx_tlast), 64'd0);
        check("rst tx_tuser", 64'(bus.tx_tuser), 64'd0);
        check("rst tx_tdest", 64'(bus.tx_tdest), 64'd0);
        check("rst rx_tready", 64'(bus.rx_tready), 64'd0);
        check("rst frame_count", bus.frame_count, 64'd0);
        check("rst drop_count", bus.drop_count, 64'd0);
        @(posedge aclk);
        #2;
        areset_n = 1'b1;

        // two simultaneous frames: port 0 wins first after reset, port 1 tuser passes through
        push_frame(0, 32'h0000_0A00, 4, 1'b0);
        push_frame(1, 32'h0000_1A00, 4, 1'b1);
        exp_frame(32'h0000_0A00, 4, 1'b0, 1'b0);
        exp_frame(32'h0000_1A00, 4, 1'b1, 1'b1);
        run_check("simul");
        check("simul frame_count", bus.frame_count, cnt(64'h0000_0001_0000_0001));
        check("simul drop_count", bus.drop_count, 64'd0);

        // back-pressure during beat 2
        consumed[0] = 0;
        push_frame(0, 32'h0000_0B00, 4, 1'b0);
        wait_consumed(0, 2);
        bus.tx_tready = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            check("stall tx_tvalid", 64'(bus.tx_tvalid), 64'd1);
            check("stall tx_tdata", 64'(bus.tx_tdata), 64'h0000_0B01);
        end
        @(posedge aclk);
        #2;
        bus.tx_tready = 1'b1;
        exp_frame(32'h0000_0B00, 4, 1'b0, 1'b0);
        run_check("stall");
        check("stall frame_count", bus.frame_count, cnt(64'h0000_0001_0000_0002));

        // last_grant is 0: order must be 1, 0, 1, 1
        push_frame(1, 32'h0000_1C00, 2, 1'b0);
        push_frame(1, 32'h0000_1D00, 2, 1'b0);
        push_frame(1, 32'h0000_1E00, 2, 1'b0);
        push_frame(0, 32'h0000_0C00, 2, 1'b0);
        exp_frame(32'h0000_1C00, 2, 1'b0, 1'b1);
        exp_frame(32'h0000_0C00, 2, 1'b0, 1'b0);
        exp_frame(32'h0000_1D00, 2, 1'b0, 1'b1);
        exp_frame(32'h0000_1E00, 2, 1'b0, 1'b1);
        run_check("rr");
        check("rr frame_count", bus.frame_count, cnt(64'h0000_0004_0000_0003));

        // link drop on port 0 after two beats of a six-beat frame
        consumed[0] = 0;
        push_frame(0, 32'h0000_0D00, 6, 1'b0);
        wait_consumed(0, 2);
        bus.link_up[0] = 1'b0;
        exp_q.push_back(ob(32'h0000_0D00, 4'hF, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ob(32'h0000_0D01, 4'hF, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ob(32'h0000_0000, 4'h0, 1'b1, 1'b1, 1'b0));
        run_check("linkdrop");
        check("linkdrop consumed", 64'(consumed[0]), 64'd6);
        check("linkdrop drop_count", bus.drop_count, cnt(64'h0000_0000_0000_0001));
        check("linkdrop frame_count", bus.frame_count, cnt(64'h0000_0004_0000_0003));
        bus.link_up[0] = 1'b1;

        // port 1 link down: frame drained, nothing forwarded
        consumed[1] = 0;
        bus.link_up[1] = 1'b0;
        push_frame(1, 32'h0000_1F00, 3, 1'b0);
        repeat (6) begin
            @(negedge aclk);
            check("down rx_tready1", 64'(bus.rx_tready[1]), 64'd1);
        end
        run_check("down");
        check("down consumed", 64'(consumed[1]), 64'd3);
        check("down drop_count", bus.drop_count, cnt(64'h0000_0001_0000_0001));
        bus.link_up[1] = 1'b1;

        // reset mid-frame, then a clean frame
        consumed[0] = 0;
        push_frame(0, 32'h0000_0E00, 4, 1'b0);
        wait_consumed(0, 2);
        areset_n = 1'b0;
        #1;
        check("midrst tx_tvalid", 64'(bus.tx_tvalid), 64'd0);
        check("midrst tx_tdata", 64'(bus.tx_tdata), 64'd0);
        check("midrst tx_tkeep", 64'(bus.tx_tkeep), 64'd0);
        check("midrst tx_tlast", 64'(bus.tx_tlast), 64'd0);
        check("midrst tx_tuser", 64'(bus.tx_tuser), 64'd0);
        check("midrst rx_tready", 64'(bus.rx_tready), 64'd0);
        check("midrst frame_count", bus.frame_count, 64'd0);
        check("midrst drop_count", bus.drop_count, 64'd0);
        src0.delete();
        out_q.delete();
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #2;
        areset_n = 1'b1;
        push_frame(0, 32'h0000_0F00, 2, 1'b0);
        exp_frame(32'h0000_0F00, 2, 1'b0, 1'b0);
        run_check("postrst");
        check("postrst frame_count", bus.frame_count, cnt(64'h0000_0000_0000_0001));
        check("postrst drop_count", bus.drop_count, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_eth_rx_arbiter.md
AXIS_ETH_RX_ARBITER -- requirements
Module: axis_eth_rx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2: number of Ethernet RX ports merged, 2..8.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: AXI-Stream tdata width in bits, a multiple of 8.
REQ-003 The block SHALL have parameter CTR_WIDTH, default 32: statistics counter width.
REQ-004 The block SHALL have port aclk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port areset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port link_up, input, NUM_PORTS bits: per-port link state, already synchronized to aclk.
REQ-007 The block SHALL have ports rx_tvalid, rx_tlast and rx_tuser (each NUM_PORTS bits), rx_tdata (NUM_PORTS x DATA_WIDTH) and rx_tkeep (NUM_PORTS x DATA_WIDTH/8), all inputs: per-port RX streams.
REQ-008 The block SHALL have port rx_tready, output, NUM_PORTS bits.
REQ-009 The block SHALL have outputs tx_tvalid (1), tx_tdata (DATA_WIDTH), tx_tkeep (DATA_WIDTH/8), tx_tlast (1), tx_tuser (1, frame error) and tx_tdest ($clog2(NUM_PORTS)), plus input tx_tready (1): the merged stream.
REQ-010 The block SHALL have outputs frame_count and drop_count, each NUM_PORTS x CTR_WIDTH.

Function
REQ-011 The block SHALL arbitrate at frame granularity: once a port is granted, only that port forwards until its tlast beat is accepted.
REQ-012 The state machine SHALL have states IDLE, FORWARD and FLUSH.
REQ-013 In IDLE, the block SHALL grant the first port p with rx_tvalid[p] & link_up[p], searching round-robin from last_grant+1 mod NUM_PORTS; it SHALL then enter FORWARD in the next cycle, and the grant cycle itself transfers no beat.
REQ-014 In FORWARD, rx_tready[g] SHALL equal !tx_tvalid | tx_tready, and rx_tready SHALL be 0 for all other link-up ports.
REQ-015 The output SHALL be a registered single-entry stage: an accepted input beat appears on tx_* exactly 1 cycle later, and tx_tdest = g.
REQ-016 Output SHALL hold stable while tx_tvalid & !tx_tready.
REQ-017 Acceptance of the granted beat with rx_tlast SHALL return the FSM to IDLE, set last_grant = g, and increment frame_count[g].
REQ-018 If link_up[g] falls in FORWARD, the next output beat SHALL be tx_tlast=1, tx_tuser=1 with tkeep=0 (a synthetic terminator, even if no input beat is available); the FSM SHALL then enter FLUSH.
REQ-019 In FLUSH, the block SHALL hold rx_tready[g]=1 and discard beats up to and including rx_tlast, then return to IDLE; drop_count[g] SHALL increment once.
REQ-020 A port with link_up low that is not granted SHALL see rx_tready=1; its beats SHALL be discarded, and drop_count increments on each discarded tlast.
REQ-021 A tlast and a link-drop occurring in the same cycle SHALL be treated as normal frame completion, with no terminator beat.
REQ-022 Input rx_tuser SHALL be forwarded to tx_tuser unchanged.
REQ-023 Counters SHALL wrap modulo 2^CTR_WIDTH.

Reset
REQ-024 While areset_n is low, the FSM SHALL be IDLE, last_grant = NUM_PORTS-1, and tx_tvalid, tx_tlast, tx_tuser, tx_tdata, tx_tkeep, tx_tdest and all counters SHALL be 0.
REQ-025 While areset_n is low, rx_tready SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without emitting a terminator beat.

Configuration
REQ-027 Macro AXIS_ETH_RX_ARBITER_STATS_EN defined: frame_count and drop_count SHALL be implemented per REQ-017 to REQ-020 and REQ-023.
REQ-028 Macro AXIS_ETH_RX_ARBITER_STATS_EN undefined: frame_count and drop_count SHALL be constant 0, with no counter registers; all other behaviour SHALL be identical.

Structure
REQ-029 Package EthernetBus SHALL hold the FSM state enum arb_state_t.
REQ-030 The round-robin priority search SHALL be sub-module axis_rr_grant: request vector and last_grant in, one-hot grant and index out, purely combinational.

Verification
REQ-031 Ports 0 and 1 each present a 4-beat frame simultaneously after reset -> port 0 frame is output first (tdest=0), then port 1 (tdest=1); frame_count = {1,1}.
REQ-032 Port 1 holds 3 back-to-back frames while port 0 presents 1 frame -> output order is 1, 0, 1, 1.
REQ-033 tx_tready held low for 5 cycles during beat 2 of a frame -> tx_tdata is stable for those 5 cycles, and no beat is lost or duplicated.
REQ-034 link_up[0] drops after beat 2 of a 6-beat frame -> output is 2 beats then a terminator (tlast=1, tuser=1, tkeep=0); the remaining 4 input beats are consumed; drop_count[0]=1.
REQ-035 link_up[1]=0 while port 1 sends a 3-beat frame -> no output; rx_tready[1]=1 throughout; drop_count[1]=1.
REQ-036 areset_n pulsed low mid-frame -> all outputs are 0 within the same cycle; after release, a new frame on port 0 is forwarded normally.
